fpu_sched: RTL and testbench
============================

// Module: fpu_sched
// PURPOSE
//  Round-robin scheduler sharing one multi-cycle FPU between NREQ requesters
//  (e.g. FP decode FSM, vector/convert helper). Latches winner's op/operands,
//  pulses fpu_go, waits fpu_valid, returns registered result + done pulse to
//  the winner. Sits between decode FSMs and the FPU core.
// PARAMETERS
//  NREQ     2   number of requesters (2..4)
//  OPW      5   FPU opcode width
//  TIMEOUT  64  watchdog limit in cycles (used only with FPU_TIMEOUT_EN)
// PORTS
//  clk          in   1         clock, all state on rising edge
//  rst          in   1         asynchronous reset, active-high
//  req          in   NREQ      request per requester; held high until done
//  req_op       in   NREQ*OPW  opcode, slice i = requester i
//  req_a        in   NREQ*32   operand A, slice i
//  req_b        in   NREQ*32   operand B, slice i
//  grant        out  NREQ      one-hot owner, high ISSUE..DONE
//  done         out  NREQ      one-cycle completion pulse to owner
//  result       out  32        registered FPU result, valid while done!=0
//  result_ireg  out  1         result targets integer regfile (latched fpu_iwb)
//  fpu_go       out  1         one-cycle start pulse to FPU
//  fpu_op       out  OPW       latched opcode, stable ISSUE..WAIT
//  fpu_a/fpu_b  out  32        latched operands, stable ISSUE..WAIT
//  fpu_valid    in   1         FPU result valid (single-cycle pulse)
//  fpu_res      in   32        FPU result
//  fpu_iwb      in   1         FPU result is for integer regfile
//  err          out  1         watchdog abort pulse (0 if FPU_TIMEOUT_EN off)
// BEHAVIOUR
//  Reset: state IDLE, rr pointer 0, grant/done/err/fpu_go 0, result/fpu_* 0.
//  States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: if |req, pick first set bit scanning ptr, ptr+1, .. (mod NREQ);
//   latch owner, op, a, b; -> ISSUE. Else stay.
//  ISSUE: fpu_go=1 exactly this cycle; -> WAIT. fpu_valid ignored here.
//  WAIT: on fpu_valid latch fpu_res->result, fpu_iwb->result_ireg; -> DONE.
//  DONE: done[owner]=1 one cycle; ptr <= (owner+1) mod NREQ; -> IDLE.
//  Latency: req high in IDLE cycle t -> fpu_go at t+1 -> done at valid+1.
//   Min 4 cycles req->done with 1-cycle FPU. Back-to-back: next ISSUE at
//   DONE+2 (IDLE re-arbitrates).
//  grant held ISSUE through DONE; fpu_op/a/b stable ISSUE..WAIT regardless of
//   req_* changes.
//  Owner dropping req mid-op: op still completes, done still pulsed.
//  Simultaneous reqs: rr order from ptr; ptr only advances on DONE, so every
//   requester is served within NREQ operations.
//  rst asserted mid-op: immediate return to reset values; in-flight FPU
//   result discarded (fpu_valid ignored in IDLE).
//  result holds last value after DONE until next WAIT capture.
// CONFIGURATION
//  FPU_TIMEOUT_EN defined: cycle counter cleared in ISSUE, counts in WAIT; if
//   it reaches TIMEOUT without fpu_valid -> err=1 and done[owner]=1 for one
//   cycle (result unchanged), ptr advances, -> IDLE.
//  Undefined: no counter, WAIT indefinitely, err tied 0.
// TESTING
//  1. req=01, op=3, a=3F800000, b=40000000, FPU valid 2 cyc after go,
//     res=40400000 -> fpu_go 1 cyc, done=01 with result=40400000.
//  2. req=11 persistent, ptr=0 -> grants 01,10,01,10 alternating; no
//     requester served twice in a row.
//  3. fpu_iwb=1 with valid -> result_ireg=1 during done; next op iwb=0 -> 0.
//  4. Change req_a mid-WAIT -> fpu_a unchanged until DONE; owner drops req
//     in WAIT -> done still pulses.
//  5. rst high during WAIT, then fpu_valid -> state IDLE, done stays 0,
//     result 0.
//  6. FPU_TIMEOUT_EN, TIMEOUT=8, no valid -> err=1 and done=owner exactly
//     8 cycles after WAIT entry; without macro waits forever, err=0.

Source files
------------

// File: rtl/fpu_sched.sv
// fpu_sched: round-robin scheduler sharing one multi-cycle FPU between NREQ requesters.
// Define FPU_TIMEOUT_EN to enable the WAIT-state watchdog (err pulse after TIMEOUT cycles).
module fpu_sched #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned OPW     = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*OPW-1:0] req_op,
  input  logic [NREQ*32-1:0]  req_a,
  input  logic [NREQ*32-1:0]  req_b,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     done,
  output logic [31:0]         result,
  output logic                result_ireg,
  output logic                fpu_go,
  output logic [OPW-1:0]      fpu_op,
  output logic [31:0]         fpu_a,
  output logic [31:0]         fpu_b,
  input  logic                fpu_valid,
  input  logic [31:0]         fpu_res,
  input  logic                fpu_iwb,
  output logic                err
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [31:0]     res_q, res_d;
  logic            ireg_q, ireg_d;
  logic            found;
  logic [IW-1:0]   pick;
  logic            timeout;
  logic [NREQ-1:0] owner_oh;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % NREQ;
    return IW'(s);
  endfunction

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && req[rr_idx(ptr_q, k)]) begin
        found = 1'b1;
        pick  = rr_idx(ptr_q, k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    ireg_d  = ireg_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          op_d    = req_op[pick*OPW +: OPW];
          a_d     = req_a[pick*32 +: 32];
          b_d     = req_b[pick*32 +: 32];
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (fpu_valid) begin
          res_d   = fpu_res;
          ireg_d  = fpu_iwb;
          state_d = DONE;
        end else if (timeout) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = rr_idx(owner_q, 1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      ireg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      ireg_q  <= ireg_d;
    end
  end

`ifdef FPU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Abort on the TIMEOUT-th WAIT cycle so done/err land TIMEOUT cycles after WAIT entry.
  assign timeout = (state_q == WAIT) && !fpu_valid && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (state_q == ISSUE) begin
      cnt_d = '0;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign owner_oh    = NREQ'(1) << owner_q;
  assign grant       = (state_q != IDLE) ? owner_oh : '0;
  assign done        = (state_q == DONE) ? owner_oh : '0;
  assign fpu_go      = (state_q == ISSUE);
  assign fpu_op      = op_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign result      = res_q;
  assign result_ireg = ireg_q;

endmodule

// File: tb/tb_fpu_sched.sv
// Randomized self-checking bench for fpu_sched against a transaction-level round-robin model.
module tb_fpu_sched;
  localparam int NREQ = 3;
  localparam int OPW  = 5;
  localparam int TO   = 64;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*OPW-1:0] req_op;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic [31:0]         result;
  logic                result_ireg;
  logic                fpu_go;
  logic [OPW-1:0]      fpu_op;
  logic [31:0]         fpu_a;
  logic [31:0]         fpu_b;
  logic                fpu_valid;
  logic [31:0]         fpu_res;
  logic                fpu_iwb;
  logic                err;

  int          n_cmp = 0;
  int          n_err = 0;
  int          ptr   = 0;
  logic [31:0] last_res = '0;

  fpu_sched #(.NREQ(NREQ), .OPW(OPW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .grant(grant), .done(done), .result(result), .result_ireg(result_ireg),
    .fpu_go(fpu_go), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_valid(fpu_valid), .fpu_res(fpu_res), .fpu_iwb(fpu_iwb), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic set_req(input int i);
    req[i]                = 1'b1;
    req_op[i*OPW +: OPW]  = OPW'($urandom);
    req_a[i*32 +: 32]     = $urandom;
    req_b[i*32 +: 32]     = $urandom;
  endtask

  // Called in an IDLE cycle with req already driven; runs one full transaction.
  task automatic do_op(input int lat, input bit spurious, input bit mutate, input bit drop,
                       input logic [31:0] res, input logic iwb);
    int              w;
    logic [OPW-1:0]  eo;
    logic [31:0]     ea, eb;
    logic [NREQ-1:0] oh;
    w  = pick(req, ptr);
    eo = req_op[w*OPW +: OPW];
    ea = req_a[w*32 +: 32];
    eb = req_b[w*32 +: 32];
    oh = NREQ'(1) << w;
    tick();
    check("issue_go", 64'(fpu_go), 64'(1));
    check("issue_grant", 64'(grant), 64'(oh));
    check("issue_op", 64'(fpu_op), 64'(eo));
    check("issue_a", 64'(fpu_a), 64'(ea));
    check("issue_b", 64'(fpu_b), 64'(eb));
    check("issue_done", 64'(done), 64'(0));
    check("result_hold", 64'(result), 64'(last_res));
    if (spurious) fpu_valid = 1'b1;
    if (mutate) begin
      req_op[w*OPW +: OPW] = ~eo;
      req_a[w*32 +: 32]    = ~ea;
      req_b[w*32 +: 32]    = ~eb;
    end
    tick();
    fpu_valid = 1'b0;
    if (drop) req[w] = 1'b0;
    for (int j = 1; j < lat; j++) begin
      check("wait_go", 64'(fpu_go), 64'(0));
      check("wait_done", 64'(done), 64'(0));
      check("wait_grant", 64'(grant), 64'(oh));
      tick();
    end
    check("wait_op", 64'(fpu_op), 64'(eo));
    check("wait_a", 64'(fpu_a), 64'(ea));
    check("wait_b", 64'(fpu_b), 64'(eb));
    fpu_valid = 1'b1;
    fpu_res   = res;
    fpu_iwb   = iwb;
    tick();
    fpu_valid = 1'b0;
    fpu_res   = $urandom;
    fpu_iwb   = 1'($urandom);
    check("done_owner", 64'(done), 64'(oh));
    check("done_result", 64'(result), 64'(res));
    check("done_ireg", 64'(result_ireg), 64'(iwb));
    check("done_grant", 64'(grant), 64'(oh));
    check("done_err", 64'(err), 64'(0));
    req[w]   = 1'b0;
    ptr      = (w + 1) % NREQ;
    last_res = res;
    tick();
    check("idle_done", 64'(done), 64'(0));
    check("idle_grant", 64'(grant), 64'(0));
    check("idle_result", 64'(result), 64'(res));
  endtask

  initial begin
    int              w, bad;
    logic [NREQ-1:0] oh;
    rst = 1'b1; req = '0; req_op = '0; req_a = '0; req_b = '0;
    fpu_valid = 1'b0; fpu_res = '0; fpu_iwb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_go", 64'(fpu_go), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_fpu_a", 64'(fpu_a), 64'(0));
    rst = 1'b0;

    // Basic single transaction, FPU answers 2 cycles after go.
    req = 3'b001; req_op[0 +: OPW] = 5'd3; req_a[0 +: 32] = 32'h3F800000; req_b[0 +: 32] = 32'h40000000;
    do_op(2, 1'b0, 1'b0, 1'b0, 32'h40400000, 1'b0);

    // Persistent pair must alternate.
    for (int n = 0; n < 4; n++) begin
      req = 3'b011;
      do_op(1, 1'b0, 1'b0, 1'b0, $urandom, 1'b0);
    end

    // Integer-writeback flag follows each result.
    set_req(2);
    do_op(3, 1'b0, 1'b0, 1'b0, $urandom, 1'b1);
    set_req(1);
    do_op(1, 1'b0, 1'b0, 1'b0, $urandom, 1'b0);

    // Operand changes and owner drop while in flight.
    set_req(0);
    do_op(4, 1'b1, 1'b1, 1'b1, $urandom, 1'b1);

    // Long FPU stall.
    set_req(1);
    w  = pick(req, ptr);
    oh = NREQ'(1) << w;
    tick();
    check("stall_go", 64'(fpu_go), 64'(1));
    tick();
    bad = 0;
    for (int j = 1; j < TO; j++) begin
      if (done != '0 || err !== 1'b0 || grant != oh) bad++;
      tick();
    end
    check("stall_quiet", 64'(bad), 64'(0));
`ifdef FPU_TIMEOUT_EN
    tick();
    check("to_done", 64'(done), 64'(oh));
    check("to_err", 64'(err), 64'(1));
    check("to_result", 64'(result), 64'(last_res));
`else
    bad = 0;
    for (int j = 0; j < 16; j++) begin
      if (done != '0 || err !== 1'b0) bad++;
      tick();
    end
    check("stall_forever", 64'(bad), 64'(0));
    fpu_valid = 1'b1;
    fpu_res   = 32'hCAFE0001;
    fpu_iwb   = 1'b0;
    tick();
    fpu_valid = 1'b0;
    check("stall_done", 64'(done), 64'(oh));
    check("stall_result", 64'(result), 64'(32'hCAFE0001));
    last_res = 32'hCAFE0001;
`endif
    req[w] = 1'b0;
    ptr    = (w + 1) % NREQ;
    tick();
    check("stall_idle_err", 64'(err), 64'(0));
    check("stall_idle_grant", 64'(grant), 64'(0));

    // Reset in the middle of WAIT; late FPU result must be dropped.
    set_req(2);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_grant", 64'(grant), 64'(0));
    check("mid_rst_result", 64'(result), 64'(0));
    check("mid_rst_fpu_a", 64'(fpu_a), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0; req = '0;
    fpu_valid = 1'b1; fpu_res = 32'h12345678;
    tick();
    fpu_valid = 1'b0;
    check("post_rst_done", 64'(done), 64'(0));
    check("post_rst_result", 64'(result), 64'(0));
    check("post_rst_grant", 64'(grant), 64'(0));
    ptr = 0; last_res = '0;
    req = '0; set_req(0); set_req(1); set_req(2);
    do_op(1, 1'b0, 1'b0, 1'b0, $urandom, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if (req == '0 && $urandom_range(2) == 0) begin
        tick();
        check("idle_stay_go", 64'(fpu_go), 64'(0));
        check("idle_stay_grant", 64'(grant), 64'(0));
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(1) == 1) set_req(i);
      end
      if (req == '0) set_req($urandom_range(NREQ - 1));
      do_op($urandom_range(1, 4), 1'($urandom), 1'($urandom), $urandom_range(3) == 0,
            $urandom, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
